// File: rtl/tuart_rx_pkg.sv
// Shared constants and types for the UART command receiver.
package tuart_rx_pkg;

  localparam int CMD_WIDTH = 40;
  localparam int OPC_WIDTH = 8;
  localparam int ARG_BYTES = 4;
  localparam int ARG_WIDTH = 8 * ARG_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  // Opcode MSB selects a long command carrying ARG_BYTES argument bytes.
  function automatic logic is_long_opc(input logic [OPC_WIDTH-1:0] opc);
    return opc[OPC_WIDTH-1];
  endfunction

endpackage

// File: rtl/tuart_rx_if.sv
// Serial input and command output bundle of the UART command receiver.
interface tuart_rx_if #(
  parameter int CMD_WIDTH = tuart_rx_pkg::CMD_WIDTH
);

  logic                 rx_i;
  logic [CMD_WIDTH-1:0] cmd_o;
  logic                 exe_o;

  modport master (output rx_i, input cmd_o, input exe_o);
  modport slave  (input rx_i, output cmd_o, output exe_o);

endinterface

// File: rtl/tuart_rx_phy.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling FSM and shifter.
//   state    | meaning
//   ST_IDLE  | line idle, waiting for a synchronized 1->0 edge
//   ST_START | timing to the start-bit mid-point, rejects glitches
//   ST_DATA  | sampling 8 data bits LSB first, one per bit period
//   ST_STOP  | sampling the stop bit, reports byte or framing error
module tuart_rx_phy #(
  parameter int CLK_PER_SAMPLE = 10
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);
  import tuart_rx_pkg::*;

  localparam int CNT_W = $clog2(CLK_PER_SAMPLE) + 1;
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLK_PER_SAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(CLK_PER_SAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic            r_sync1;
  logic            r_sync2;
  logic            r_rx_d;
  rx_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;

  logic w_rx;
  logic w_fall;

  assign w_rx   = r_sync2;
  assign w_fall = r_rx_d & ~r_sync2;

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  // The cycle counter runs down to zero; each terminal count is one sample point.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_cnt   <= HALF_LD;
            r_bit   <= '0;
          end
        end
        ST_START: begin
          if (r_cnt == '0) begin
            if (!w_rx) begin
              r_state <= ST_DATA;
              r_cnt   <= BIT_LD;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= BIT_LD;
            if (r_bit == 3'd7) begin
              r_state <= ST_STOP;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_STOP: begin
          if (r_cnt == '0) begin
            if (w_rx) begin
              valid_o <= 1'b1;
              data_o  <= r_shift;
            end else begin
              frame_err_o <= 1'b1;
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tuart_rx.sv
// UART command receiver: assembles short (opcode) and long (opcode + 4 bytes) commands.
module tuart_rx #(
  parameter int CLK_PER_SAMPLE = 10,
  parameter int CMD_WIDTH      = tuart_rx_pkg::CMD_WIDTH
) (
  input  logic       clk_i,
  input  logic       rst_in,
  tuart_rx_if.slave  bus
);
  import tuart_rx_pkg::*;

  localparam logic [2:0] LAST_IDX = 3'(ARG_BYTES);

  logic [7:0]           w_byte;
  logic                 w_valid;
  logic                 w_ferr;
  logic                 w_short_done;
  logic                 w_long_done;
  logic                 w_exe;
  logic [CMD_WIDTH-1:0] w_cmd_next;

  logic [2:0]           r_idx;
  logic [OPC_WIDTH-1:0] r_opc;
  logic [ARG_WIDTH-1:0] r_arg;
  logic [CMD_WIDTH-1:0] r_cmd;

  tuart_rx_phy #(
    .CLK_PER_SAMPLE(CLK_PER_SAMPLE)
  ) u_phy (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .rx_i        (bus.rx_i),
    .data_o      (w_byte),
    .valid_o     (w_valid),
    .frame_err_o (w_ferr)
  );

  // Completion is decoded from the registered byte strobe so exe_o and cmd_o
  // appear in the cycle right after the stop-bit sample.
  always_comb begin
    w_short_done = w_valid && (r_idx == '0) && !is_long_opc(w_byte);
    w_long_done  = w_valid && (r_idx == LAST_IDX);
    w_exe        = w_short_done || w_long_done;
    w_cmd_next   = r_cmd;
    if (w_short_done) begin
      w_cmd_next = CMD_WIDTH'(w_byte);
    end else if (w_long_done) begin
      w_cmd_next = CMD_WIDTH'({w_byte, r_arg[ARG_WIDTH-1:8], r_opc});
    end
  end

  // Argument bytes enter at the top of r_arg so the first one ends lowest.
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_idx <= '0;
      r_opc <= '0;
      r_arg <= '0;
      r_cmd <= '0;
    end else begin
      r_cmd <= w_cmd_next;
      if (w_ferr) begin
        r_idx <= '0;
      end else if (w_valid) begin
        if (r_idx == '0) begin
          if (is_long_opc(w_byte)) begin
            r_opc <= w_byte;
            r_arg <= '0;
            r_idx <= 3'd1;
          end
        end else begin
          r_arg <= {w_byte, r_arg[ARG_WIDTH-1:8]};
          r_idx <= w_long_done ? 3'd0 : r_idx + 3'd1;
        end
      end
    end
  end

  assign bus.exe_o = w_exe;
  assign bus.cmd_o = w_cmd_next;

endmodule

// File: tb/tb_tuart_rx.sv
// Randomized bench for tuart_rx against a byte-list command model.
module tb_tuart_rx;

  localparam int CPS = 10;

  logic clk_i;
  logic rst_in;

  tuart_rx_if #(.CMD_WIDTH(40)) bus ();

  tuart_rx #(
    .CLK_PER_SAMPLE(CPS),
    .CMD_WIDTH     (40)
  ) dut (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .bus    (bus.slave)
  );

  int n_checks;
  int n_fail;

  logic [7:0]  pend_q[$];
  logic [39:0] exp_q[$];
  logic [39:0] obs_q[$];
  logic [39:0] last_cmd;
  logic        prev_exe;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A command is the list of accepted bytes since the last completion or error.
  function automatic void model_byte(input logic [7:0] d, input logic stop_ok);
    logic [39:0] cmd;
    if (!stop_ok) begin
      pend_q.delete();
      return;
    end
    pend_q.push_back(d);
    if (pend_q[0][7] == 1'b0) begin
      cmd = {32'h0, pend_q[0]};
    end else if (pend_q.size() == 5) begin
      cmd = {pend_q[4], pend_q[3], pend_q[2], pend_q[1], pend_q[0]};
    end else begin
      return;
    end
    exp_q.push_back(cmd);
    last_cmd = cmd;
    pend_q.delete();
  endfunction

  always @(negedge clk_i) begin
    if (rst_in && bus.exe_o) begin
      obs_q.push_back(bus.cmd_o);
      check_eq("exe_one_cycle", 64'(prev_exe), 64'(0));
    end
    prev_exe <= rst_in & bus.exe_o;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive_bit(input logic b);
    bus.rx_i = b;
    idle(CPS);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_ok);
    model_byte(d, stop_ok);
    if (!stop_ok) begin
      bus.rx_i = 1'b1;
      idle(2 * CPS);
    end
  endtask

  task automatic partial_byte(input logic [7:0] d, input int nbits);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(d[i]);
  endtask

  task automatic glitch(input int n);
    bus.rx_i = 1'b0;
    idle(n);
    bus.rx_i = 1'b1;
    idle(2 * CPS);
  endtask

  task automatic do_reset();
    bus.rx_i = 1'b1;
    rst_in   = 1'b0;
    idle(3);
    check_eq("rst_cmd", 64'(bus.cmd_o), 64'(0));
    check_eq("rst_exe", 64'(bus.exe_o), 64'(0));
    rst_in = 1'b1;
    pend_q.delete();
    last_cmd = '0;
    idle(2);
  endtask

  task automatic scn_end(input string tag);
    bus.rx_i = 1'b1;
    idle(3 * CPS);
    check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check_eq({tag, "_cmd"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
    check_eq({tag, "_hold"}, 64'(bus.cmd_o), 64'(last_cmd));
  endtask

  initial begin
    logic [7:0] opc;
    logic       is_long;
    n_checks = 0;
    n_fail   = 0;
    prev_exe = 1'b0;
    last_cmd = '0;
    bus.rx_i = 1'b1;
    rst_in   = 1'b0;
    idle(4);
    check_eq("init_cmd", 64'(bus.cmd_o), 64'(0));
    check_eq("init_exe", 64'(bus.exe_o), 64'(0));
    rst_in = 1'b1;
    idle(5);

    send_byte(8'h01, 1'b1);
    scn_end("short");
    check_eq("short_lit", 64'(bus.cmd_o), 64'h01);

    send_byte(8'h80, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    scn_end("long");
    check_eq("long_lit", 64'(bus.cmd_o), 64'h44_3322_1180);

    glitch(2);
    scn_end("glitch");
    send_byte(8'h02, 1'b1);
    scn_end("post_glitch");
    check_eq("glitch_lit", 64'(bus.cmd_o), 64'h02);

    send_byte(8'h80, 1'b1);
    send_byte(8'h5A, 1'b0);
    send_byte(8'h03, 1'b1);
    scn_end("frame_err");
    check_eq("ferr_lit", 64'(bus.cmd_o), 64'h03);

    send_byte(8'h80, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    scn_end("partial");
    partial_byte(8'hCC, 4);
    do_reset();
    send_byte(8'h05, 1'b1);
    scn_end("reset_mid");
    check_eq("reset_lit", 64'(bus.cmd_o), 64'h05);

    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    scn_end("b2b");
    check_eq("b2b_lit", 64'(bus.cmd_o), 64'h02);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 9))
        0: glitch($urandom_range(1, 3));
        1: send_byte(8'($urandom), 1'b0);
        2: begin
          partial_byte(8'($urandom), $urandom_range(0, 7));
          do_reset();
        end
        default: begin
          is_long = 1'($urandom_range(0, 1));
          opc     = {is_long, 7'($urandom)};
          send_byte(opc, 1'b1);
          if (is_long) begin
            for (int k = 0; k < 4; k++) begin
              idle($urandom_range(0, 12));
              send_byte(8'($urandom), ($urandom_range(0, 7) != 0));
            end
          end
        end
      endcase
      idle($urandom_range(0, 12));
      scn_end("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tuart_rx.md
TUART_RX -- requirements
Module: tuart_rx

Interface
REQ-001 SHALL have parameter CLK_PER_SAMPLE, default 10, clock cycles per UART bit period.
REQ-002 SHALL have parameter CMD_WIDTH, default 40, width of the assembled command (opcode plus 32-bit argument).
REQ-003 SHALL use one clock; reset is asynchronous and active-low; ports are named clk_i and rst_in.
REQ-004 SHALL have port clk_i, input, 1, system clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_in, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx_i, input, 1, asynchronous UART serial line, idle high.
REQ-007 SHALL have port cmd_o, output, CMD_WIDTH, last completed command: [7:0] opcode, [39:8] argument.
REQ-008 SHALL have port exe_o, output, 1, single-cycle strobe marking a new valid cmd_o.

Function
REQ-009 SHALL pass rx_i through a 2-flop synchronizer whose flops reset to 1; all decoding uses the synchronized value.
REQ-010 SHALL frame 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-011 SHALL implement byte FSM states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on a synchronized 1->0 transition; the bit counter is cleared.
REQ-013 START: re-sample at CLK_PER_SAMPLE/2 cycles; if 0 -> DATA, if 1 (glitch) -> IDLE with nothing recorded.
REQ-014 DATA: sample every CLK_PER_SAMPLE cycles after the start mid-point; shift in LSB first; after bit 7 -> STOP.
REQ-015 STOP: sample once CLK_PER_SAMPLE cycles later; 1 -> byte accepted; 0 -> framing error, byte discarded, command assembly cleared; either way -> IDLE.
REQ-016 Command assembly SHALL treat the first accepted byte as opcode; opcode[7]=0 is a short command, opcode[7]=1 a long command followed by exactly 4 argument bytes.
REQ-017 Argument bytes SHALL fill cmd_o[15:8], [23:16], [31:24], [39:32] in arrival order.
REQ-018 For a short command, cmd_o[39:8] SHALL be 0.
REQ-019 exe_o SHALL pulse high for exactly one cycle, in the cycle after the stop bit of the final command byte is sampled; cmd_o is valid in that same cycle.
REQ-020 cmd_o SHALL hold its value until the next command completes; partial commands SHALL NOT alter cmd_o.
REQ-021 A start edge arriving during STOP after the stop sample SHALL be detected, so back-to-back frames are supported.
REQ-022 Counters SHALL be sized to $clog2(CLK_PER_SAMPLE)+1 bits with no wrap-around within a bit period.

Reset
REQ-023 Reset SHALL force FSM=IDLE, bit and cycle counters=0, byte index=0, cmd_o=0, exe_o=0, synchronizer flops=1.
REQ-024 Reset asserted mid-frame or mid-command SHALL discard all partial data; no exe_o after release until a full new command is received.

Structure
REQ-025 A shared package SHALL hold CMD_WIDTH, the opcode width (8), the argument byte count (4) and the FSM state enum type.
REQ-026 The byte receiver (sync + FSM + shifter) SHALL be a sub-module tuart_rx_phy with outputs data[7:0], valid and frame_err; tuart_rx adds command assembly.

Verification
REQ-027 Short command: send 0x01 -> one exe_o pulse, cmd_o=0x00_0000_0001.
REQ-028 Long command: send 0x80, 0x11, 0x22, 0x33, 0x44 -> exactly one exe_o, after the last byte, cmd_o=0x44_3322_1180.
REQ-029 Glitch: drive rx_i low for 2 cycles -> no byte and no exe_o; a following 0x02 -> cmd_o=0x02.
REQ-030 Framing error: send 0x80 then a byte with stop=0, then 0x03 -> exe_o once, cmd_o=0x03.
REQ-031 Reset mid-long-command after 2 argument bytes, then send 0x05 -> single exe_o, cmd_o=0x05.
REQ-032 Back-to-back short commands 0x01, 0x02 with no idle gap -> two exe_o pulses, with cmd_o equal to 0x01 then 0x02.
